i2c_wb_slave_bfm: RTL and testbench



---
 rtl/i2c_wb_slave_pkg.sv | 28 ++
 rtl/i2c_line_sync.sv | 43 ++++
 rtl/i2c_wb_slave_bfm.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_i2c_wb_slave_bfm.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_wb_slave_pkg.sv
// rtl/i2c_wb_slave_pkg.sv - shared FSM type and register constants for the I2C Wishbone slave responder
package i2c_wb_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_state_e;

    // Wishbone register map
    localparam int REG_CTRL = 0;
    localparam int REG_SADR = 1;
    localparam int REG_TXD  = 2;
    localparam int REG_RXD  = 3;

    // CTRL bit positions
    localparam int CTRL_EN   = 7;
    localparam int CTRL_RXV  = 6;
    localparam int CTRL_BUSY = 5;
    localparam int CTRL_HIT  = 4;
    localparam int CTRL_IE   = 3;

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - two-flop synchronizer with SCL edge and START/STOP detection for one bus
module i2c_line_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic sda_o,
    output logic start_o,
    output logic stop_o
);

    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;

    // Synchronize both lines; reset to the idle (released, high) bus level
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_i;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= sda_i;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
        end
    end

    assign scl_rise_o = scl_sync_q & ~scl_prev_q;
    assign scl_fall_o = ~scl_sync_q & scl_prev_q;
    assign sda_o      = sda_sync_q;
    // SCL must be steadily high across the SDA transition to count as START/STOP
    assign start_o    = sda_prev_q & ~sda_sync_q & scl_sync_q & scl_prev_q;
    assign stop_o     = ~sda_prev_q & sda_sync_q & scl_sync_q & scl_prev_q;

endmodule

// File: rtl/i2c_wb_slave_bfm.sv
// rtl/i2c_wb_slave_bfm.sv - I2C slave responder with Wishbone registers; IRQ enabled by I2C_WB_SLAVE_IRQ_EN
module i2c_wb_slave_bfm
    import i2c_wb_slave_pkg::*;
#(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int NUM_I2C_BUSSES = 16,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int I2C_DATA_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cyc_i,
    input  logic                      stb_i,
    input  logic                      we_i,
    input  logic [WB_ADDR_WIDTH-1:0]  adr_i,
    input  logic [WB_DATA_WIDTH-1:0]  dat_i,
    output logic [WB_DATA_WIDTH-1:0]  dat_o,
    output logic                      ack_o,
    output logic                      irq,
    input  logic [NUM_I2C_BUSSES-1:0] scl_i,
    input  logic [NUM_I2C_BUSSES-1:0] sda_i,
    output logic [NUM_I2C_BUSSES-1:0] sda_oe
);

    localparam logic [3:0] LAST_BIT = 4'(I2C_DATA_WIDTH - 1);
    localparam logic [3:0] NUM_BITS = 4'(I2C_DATA_WIDTH);

    // Software-visible registers
    logic                      en_q, rxv_q, hit_q, ie;
    logic [I2C_ADDR_WIDTH-1:0] sadr_q;
    logic [I2C_DATA_WIDTH-1:0] txd_q, rxd_q;
    logic [3:0]                bsel_q;
    logic                      ack_q, hold_q;
    logic [WB_DATA_WIDTH-1:0]  dat_q, rd_data, ctrl_rd;

    // I2C engine state
    i2c_state_e                state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [I2C_DATA_WIDTH-1:0] shift_q, shift_d, rx_byte;
    logic                      pull_q, pull_d;
    logic                      phase_q, phase_d;
    logic                      nack_q, nack_d;
    logic                      rw_q, rw_d;
    logic                      rx_load, hit_set, hit_clr;

    logic scl_rise, scl_fall, sda_s, start_s, stop_s;
    logic wb_req, wb_wr, wb_rd, force_idle;

    i2c_line_sync u_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .scl_i      (scl_i[bsel_q]),
        .sda_i      (sda_i[bsel_q]),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .sda_o      (sda_s),
        .start_o    (start_s),
        .stop_o     (stop_s)
    );

    // hold_q blocks a second ack while the master keeps stb_i asserted
    assign wb_req     = cyc_i & stb_i & ~ack_q & ~hold_q;
    assign wb_wr      = wb_req & we_i;
    assign wb_rd      = wb_req & ~we_i;
    assign force_idle = ~en_q | (wb_wr & ((adr_i == WB_ADDR_WIDTH'(REG_CTRL)) |
                                          (adr_i == WB_ADDR_WIDTH'(REG_RXD))));

    // Assemble CTRL read value from live status bits
    always_comb begin
        ctrl_rd            = '0;
        ctrl_rd[CTRL_EN]   = en_q;
        ctrl_rd[CTRL_RXV]  = rxv_q;
        ctrl_rd[CTRL_BUSY] = (state_q != ST_IDLE);
        ctrl_rd[CTRL_HIT]  = hit_q;
        ctrl_rd[CTRL_IE]   = ie;
    end

    // Read data mux
    always_comb begin
        rd_data = '0;
        if (adr_i == WB_ADDR_WIDTH'(REG_CTRL))      rd_data = ctrl_rd;
        else if (adr_i == WB_ADDR_WIDTH'(REG_SADR)) rd_data = WB_DATA_WIDTH'(sadr_q);
        else if (adr_i == WB_ADDR_WIDTH'(REG_TXD))  rd_data = WB_DATA_WIDTH'(txd_q);
        else                                        rd_data = WB_DATA_WIDTH'(rxd_q);
    end

    // Wishbone handshake, register writes and status flag updates
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q  <= 1'b0;
            hold_q <= 1'b0;
            dat_q  <= '0;
            en_q   <= 1'b0;
            sadr_q <= '0;
            txd_q  <= '0;
            rxd_q  <= '0;
            bsel_q <= '0;
            rxv_q  <= 1'b0;
            hit_q  <= 1'b0;
        end else begin
            ack_q  <= wb_req;
            hold_q <= cyc_i & stb_i & (ack_q | hold_q);
            if (wb_rd) dat_q <= rd_data;
            if (wb_wr) begin
                if (adr_i == WB_ADDR_WIDTH'(REG_CTRL))      en_q   <= dat_i[CTRL_EN];
                else if (adr_i == WB_ADDR_WIDTH'(REG_SADR)) sadr_q <= dat_i[I2C_ADDR_WIDTH-1:0];
                else if (adr_i == WB_ADDR_WIDTH'(REG_TXD))  txd_q  <= dat_i[I2C_DATA_WIDTH-1:0];
                else                                        bsel_q <= dat_i[3:0];
            end
            // A freshly received byte wins over a simultaneous RXD read
            if (rx_load) begin
                rxd_q <= rx_byte;
                rxv_q <= 1'b1;
            end else if (wb_rd && adr_i == WB_ADDR_WIDTH'(REG_RXD)) begin
                rxv_q <= 1'b0;
            end
            if (hit_set)      hit_q <= 1'b1;
            else if (hit_clr) hit_q <= 1'b0;
        end
    end

`ifdef I2C_WB_SLAVE_IRQ_EN
    logic ie_q, irq_q;

    // Interrupt enable register and registered interrupt output
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (wb_wr && adr_i == WB_ADDR_WIDTH'(REG_CTRL)) ie_q <= dat_i[CTRL_IE];
            irq_q <= ie_q & rxv_q;
        end
    end

    assign ie  = ie_q;
    assign irq = irq_q;
`else
    assign ie  = 1'b0;
    assign irq = 1'b0;
`endif

    // I2C engine state register; async reset releases SDA at once
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            pull_q  <= 1'b0;
            phase_q <= 1'b0;
            nack_q  <= 1'b0;
            rw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            pull_q  <= pull_d;
            phase_q <= phase_d;
            nack_q  <= nack_d;
            rw_q    <= rw_d;
        end
    end

    // I2C engine next state: sample on SCL rise, change SDA on SCL fall
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        pull_d  = pull_q;
        phase_d = phase_q;
        nack_d  = nack_q;
        rw_d    = rw_q;
        rx_load = 1'b0;
        hit_set = 1'b0;
        hit_clr = 1'b0;
        rx_byte = {shift_q[I2C_DATA_WIDTH-2:0], sda_s};

        if (force_idle || stop_s) begin
            state_d = ST_IDLE;
            pull_d  = 1'b0;
        end else if (start_s) begin
            state_d = ST_ADDR;
            cnt_d   = '0;
            pull_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == LAST_BIT) begin
                            rw_d    = sda_s;
                            phase_d = 1'b0;
                            cnt_d   = '0;
                            if (shift_q[I2C_ADDR_WIDTH-1:0] == sadr_q) begin
                                hit_set = 1'b1;
                                state_d = ST_ADDR_ACK;
                            end else begin
                                hit_clr = 1'b1;
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                // First fall after the 8th bit starts the ACK, the next fall ends it
                ST_ADDR_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            pull_d  = 1'b1;
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            cnt_d   = '0;
                            pull_d  = 1'b0;
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                state_d = ST_RD_DATA;
                                shift_d = txd_q;
                                pull_d  = ~txd_q[I2C_DATA_WIDTH-1];
                            end else begin
                                state_d = ST_WR_DATA;
                            end
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == LAST_BIT) begin
                            rx_load = 1'b1;
                            phase_d = 1'b0;
                            cnt_d   = '0;
                            state_d = ST_WR_ACK;
                        end
                    end
                end
                // MSB is already on the line at entry; cnt counts bits the master has clocked
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == NUM_BITS) begin
                            pull_d  = 1'b0;
                            cnt_d   = '0;
                            state_d = ST_RD_ACK;
                        end else begin
                            pull_d  = ~shift_q[I2C_DATA_WIDTH-2];
                            shift_d = {shift_q[I2C_DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        nack_d = sda_s;
                    end else if (scl_fall) begin
                        if (!nack_q) begin
                            state_d = ST_RD_DATA;
                            shift_d = txd_q;
                            pull_d  = ~txd_q[I2C_DATA_WIDTH-1];
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_IGNORE;
                            pull_d  = 1'b0;
                        end
                    end
                end
                ST_IGNORE: pull_d = 1'b0;
                ST_IDLE:   pull_d = 1'b0;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Route the engine's SDA pull onto the selected bus only
    always_comb begin
        sda_oe = '0;
        if (pull_q && en_q) sda_oe[bsel_q] = 1'b1;
    end

    assign ack_o = ack_q;
    assign dat_o = dat_q;

endmodule

// File: tb/tb_i2c_wb_slave_bfm.sv
// tb/tb_i2c_wb_slave_bfm.sv - directed self-checking bench for i2c_wb_slave_bfm
module tb_i2c_wb_slave_bfm;

    localparam time Q = 40ns;

`ifdef I2C_WB_SLAVE_IRQ_EN
    localparam logic       IRQ_ON = 1'b1;
    localparam logic [7:0] IE_BIT = 8'h08;
`else
    localparam logic       IRQ_ON = 1'b0;
    localparam logic [7:0] IE_BIT = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [1:0]  adr = '0;
    logic [7:0]  wdat = '0;
    logic [7:0]  dat_o;
    logic        ack_o, irq;
    logic [15:0] scl_m = '1, sda_m = '1;
    logic [15:0] sda_line, sda_oe;

    int n_checks = 0;
    int n_pass   = 0;
    int oe_cnt   = 0;
    logic [15:0] oe_mid;
    int oe_bad;

    assign sda_line = sda_m & ~sda_oe;

    i2c_wb_slave_bfm dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .cyc_i  (cyc),
        .stb_i  (stb),
        .we_i   (we),
        .adr_i  (adr),
        .dat_i  (wdat),
        .dat_o  (dat_o),
        .ack_o  (ack_o),
        .irq    (irq),
        .scl_i  (scl_m),
        .sda_i  (sda_line),
        .sda_oe (sda_oe)
    );

    always #5ns clk = ~clk;

    always @(negedge clk) if (sda_oe != 16'h0) oe_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [7:0] d,
                           output logic [7:0] rd, output int acks);
        bit got = 0;
        rd = 'x;
        acks = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (ack_o) begin
                got = 1;
                acks++;
                rd = dat_o;
            end
        end
        if (!got) check("wb_ack_timeout", 0, 1);
        repeat (2) begin
            @(negedge clk);
            if (ack_o) acks++;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] rd;
        int acks;
        wb_xfer(1'b1, a, d, rd, acks);
    endtask

    task automatic wb_read_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] rd;
        int acks;
        wb_xfer(1'b0, a, 8'h00, rd, acks);
        check(tag, rd, exp);
    endtask

    task automatic i2c_start(input int b);
        sda_m[b] = 1'b1; #Q; scl_m[b] = 1'b1; #Q; sda_m[b] = 1'b0; #Q; scl_m[b] = 1'b0; #Q;
    endtask

    task automatic i2c_stop(input int b);
        sda_m[b] = 1'b0; #Q; scl_m[b] = 1'b1; #Q; sda_m[b] = 1'b1; #Q;
    endtask

    task automatic i2c_bit(input int b, input logic v, output logic seen);
        sda_m[b] = v; #Q;
        scl_m[b] = 1'b1; #Q;
        seen = sda_line[b];
        oe_mid = sda_oe;
        #Q;
        scl_m[b] = 1'b0; #Q;
    endtask

    task automatic i2c_write_byte(input int b, input logic [7:0] d, output logic ack);
        logic s;
        oe_bad = 0;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(b, d[i], s);
            if (oe_mid != 16'h0) oe_bad++;
        end
        i2c_bit(b, 1'b1, ack);
    endtask

    task automatic i2c_read_byte(input int b, input logic m_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(b, 1'b1, s);
            d[i] = s;
        end
        i2c_bit(b, m_ack, s);
    endtask

    initial begin
        logic [7:0] rd;
        logic       ack, s;
        int         acks, base;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_sda_oe", sda_oe, 16'h0);
        check("rst_ack", ack_o, 0);
        check("rst_dat", dat_o, 8'h00);
        check("rst_irq", irq, 0);
        rst = 1'b0;
        @(negedge clk);
        wb_xfer(1'b0, 2'd0, 8'h00, rd, acks);
        check("rst_ctrl", rd, 8'h00);
        check("ack_width", acks, 1);
        wb_read_chk("rst_sadr", 2'd1, 8'h00);
        wb_read_chk("rst_txd", 2'd2, 8'h00);
        wb_read_chk("rst_rxd", 2'd3, 8'h00);

        // Setup: address 0x22 on bus 5
        wb_write(2'd1, 8'h22);
        wb_write(2'd3, 8'h05);
        wb_write(2'd0, 8'h80);
        wb_read_chk("ctrl_en", 2'd0, 8'h80);
        wb_read_chk("sadr_rb", 2'd1, 8'h22);

        // Master write 0x44, 0xA5
        i2c_start(5);
        i2c_write_byte(5, 8'h44, ack);
        check("wr_addr_ack", ack, 0);
        check("wr_addr_oe_data", oe_bad, 0);
        check("wr_addr_oe_ack", oe_mid, 16'h0020);
        wb_read_chk("ctrl_busy_hit", 2'd0, 8'hB0);
        i2c_write_byte(5, 8'hA5, ack);
        check("wr_data_ack", ack, 0);
        check("wr_data_oe_data", oe_bad, 0);
        check("wr_data_oe_ack", oe_mid, 16'h0020);
        i2c_stop(5);
        wb_read_chk("ctrl_rxv", 2'd0, 8'hD0);
        wb_read_chk("rxd_a5", 2'd3, 8'hA5);
        wb_read_chk("ctrl_rxv_clr", 2'd0, 8'h90);

        // Master read two bytes of TXD
        wb_write(2'd2, 8'h3C);
        i2c_start(5);
        i2c_write_byte(5, 8'h45, ack);
        check("rd_addr_ack", ack, 0);
        i2c_read_byte(5, 1'b0, rd);
        check("rd_byte0", rd, 8'h3C);
        i2c_read_byte(5, 1'b1, rd);
        check("rd_byte1", rd, 8'h3C);
        i2c_stop(5);
        wb_read_chk("ctrl_after_rd", 2'd0, 8'h90);

        // Wrong address 0x23
        base = oe_cnt;
        i2c_start(5);
        i2c_write_byte(5, 8'h46, ack);
        check("nack_addr", ack, 1);
        wb_read_chk("ctrl_nohit", 2'd0, 8'hA0);
        i2c_stop(5);
        check("nack_no_oe", oe_cnt - base, 0);
        wb_read_chk("ctrl_nohit_idle", 2'd0, 8'h80);

        // Write then repeated-start read with IE set
        wb_write(2'd0, 8'h88);
        wb_read_chk("ctrl_ie", 2'd0, 8'h80 | IE_BIT);
        i2c_start(5);
        i2c_write_byte(5, 8'h44, ack);
        check("irq_addr_ack", ack, 0);
        check("irq_low_before", irq, 0);
        i2c_write_byte(5, 8'h10, ack);
        check("irq_data_ack", ack, 0);
        repeat (3) @(negedge clk);
        check("irq_high", irq, IRQ_ON);
        wb_read_chk("ctrl_irq_busy", 2'd0, 8'hF0 | IE_BIT);
        i2c_start(5);
        i2c_write_byte(5, 8'h45, ack);
        check("rs_addr_ack", ack, 0);
        i2c_read_byte(5, 1'b1, rd);
        check("rs_rd_byte", rd, 8'h3C);
        i2c_stop(5);
        check("irq_held", irq, IRQ_ON);
        wb_read_chk("rxd_10", 2'd3, 8'h10);
        check("irq_cleared", irq, 0);

        // Traffic on unselected bus 4
        base = oe_cnt;
        i2c_start(4);
        i2c_write_byte(4, 8'h44, ack);
        check("bus4_nack", ack, 1);
        wb_read_chk("bus4_not_busy", 2'd0, 8'h90 | IE_BIT);
        i2c_stop(4);
        check("bus4_no_oe", oe_cnt - base, 0);

        // Disabled: no response on the selected bus
        wb_write(2'd0, 8'h00);
        base = oe_cnt;
        i2c_start(5);
        i2c_write_byte(5, 8'h44, ack);
        check("dis_nack", ack, 1);
        wb_read_chk("dis_ctrl", 2'd0, 8'h10);
        i2c_stop(5);
        check("dis_no_oe", oe_cnt - base, 0);

        // Reset during an ACK releases SDA without waiting for a clock
        wb_write(2'd0, 8'h80);
        i2c_start(5);
        for (int i = 7; i >= 0; i--) i2c_bit(5, (8'h44 >> i) & 8'h01, s);
        #Q;
        check("pre_rst_oe", sda_oe, 16'h0020);
        @(posedge clk);
        #2ns;
        rst = 1'b1;
        #1ns;
        check("async_rst_oe", sda_oe, 16'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        i2c_stop(5);
        wb_read_chk("post_rst_ctrl", 2'd0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
